mult_bus_scheduler: RTL and testbench
=====================================

# mult_bus_scheduler

Round-robin scheduler that shares one 8-bit bus-based `Multiplier` among `N_REQ` requesters. It grants one request at a time and sequences the multiplier's start/operand/result protocol over the shared `databus`. It collects the two result bytes and returns a 16-bit product with a one-cycle acknowledge. It sits between the requesting blocks and the multiplier; top level resolves `databus` from `bus_out`/`bus_oe`.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: max cycles in WAIT before abort, ≥4.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: request per requester; level, held until ack.
- `opnd_a` in 8*N_REQ: first operand, requester i at [8i+7:8i]; stable while req[i]=1.
- `opnd_b` in 8*N_REQ: second operand, same packing.
- `ack` out N_REQ: one-hot, one-cycle pulse to the granted requester.
- `result` out 16: product, valid in the ack cycle, held until the next grant.
- `err` out 1: timeout flag, valid in the ack cycle.
- `busy` out 1: high in any state but IDLE.
- `start` out 1: multiplier start strobe.
- `bus_out` out 8: byte driven onto databus.
- `bus_oe` out 1: drive enable for databus.
- `bus_in` in 8: resolved databus value.
- `lsb_out` in 1: multiplier is presenting the result LSB on the bus.
- `msb_out` in 1: multiplier is presenting the result MSB on the bus.
- `done` in 1: multiplier finished.

## Operation

- All outputs are registered.
- Reset values: state IDLE, `ack`=0, `result`=0, `err`=0, `busy`=0, `start`=0, `bus_oe`=0, `bus_out`=0, round-robin pointer=0, timeout counter=0.
- **IDLE:** sample `req`. Pick the first set bit at or after the pointer, wrapping modulo N_REQ. Latch the grant index and both operands, clear the result register, go to SEND_A. If no request, stay.
- **SEND_A (1 cycle):** `start`=1, `bus_oe`=1, `bus_out`=opnd_a. Go to SEND_B.
- **SEND_B (1 cycle):** `start`=0, `bus_oe`=1, `bus_out`=opnd_b. Go to WAIT.
- **WAIT:**
  - `bus_oe`=0. The counter increments each cycle.
  - `lsb_out`=1 captures `bus_in` into result[7:0]; `msb_out`=1 captures it into result[15:8]. Both may be captured in the same cycle as `done`.
  - `done`=1 goes to RESP with err=0.
  - If the counter reaches TIMEOUT-1 without `done`, go to RESP with err=1 and result forced to 0.
- **RESP (1 cycle):** `ack[grant]`=1, `result`/`err` presented. Pointer becomes (grant+1) mod N_REQ. Go to IDLE.
- Requester rule: deassert `req` on the edge that samples `ack`=1. A `req` still high in the following IDLE is treated as a new request.
- Requests arriving during a transaction wait; they are never lost or merged.
- `lsb_out` or `msb_out` outside WAIT is ignored.
- A repeated `lsb_out` or `msb_out` in WAIT overwrites the captured byte.
- `rst` during any state returns to reset values on the next edge. No `ack` is issued for the aborted transaction, and `bus_oe` drops immediately.

## Timing

- A request sampled in IDLE at edge E0 gives SEND_A in E0+1, SEND_B in E0+2, WAIT from E0+3.
- If `done` is sampled at edge Ed, RESP/`ack` is high in the cycle after Ed, and `busy` drops one cycle later.
- Minimum request-to-ack: 5 cycles (`done` sampled on the first WAIT edge).
- Back-to-back: the next grant's SEND_A is at the earliest 2 cycles after the ack cycle (RESP, then IDLE).
- `start` is exactly one cycle wide, coincident with opnd_a on the bus.
- `bus_oe` is high for exactly 2 cycles per transaction.
- Timeout: RESP occurs TIMEOUT cycles after entering WAIT.

## Test plan

- Single request, `req[0]`, opnd 0x0F × 0x11, behavioural multiplier model → start pulse with bus=0x0F, next cycle bus=0x11, `ack[0]` with result=0x00FF, err=0.
- All four `req` high at once, operands i+1 × 2 → acks in order 0,1,2,3, results 2,4,6,8; `start` never overlaps a WAIT.
- `req[2]` held continuously while `req[1]` pulses → grants alternate 2,1,2 with no starvation; pointer wraps past N_REQ-1 to 0.
- Model never asserts `done` → `ack` with err=1 and result=0x0000 exactly TIMEOUT cycles after WAIT entry; the next request completes normally.
- 0xFF × 0xFF with `msb_out` and `done` in the same cycle → result=0xFE01.
- `rst` asserted in SEND_B and in WAIT → outputs at reset values next cycle, no ack; after release, a pending `req[3]` is granted first (pointer=0, scan finds 3).

Source files
------------

// File: rtl/mult_bus_scheduler.sv
// mult_bus_scheduler
//   Shares one 8-bit bus-based multiplier among N_REQ requesters. A round-robin
//   arbiter grants one request at a time. The block then drives the start strobe
//   and both operands onto the shared databus, and collects the two result bytes
//   the multiplier returns. It answers the granted requester with a 16-bit
//   product and a one-cycle ack. A WAIT that runs too long is aborted with err=1.
//
// Ports
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   req              : per-requester request level, held until ack
//   opnd_a, opnd_b   : packed operands, requester i at [8i+7:8i]
//   ack              : one-hot, one-cycle acknowledge to the granted requester
//   result, err      : product and timeout flag, valid in the ack cycle
//   busy             : high whenever a transaction is in flight
//   start            : multiplier start strobe (coincident with operand A)
//   bus_out, bus_oe  : byte and drive enable for the shared databus
//   bus_in           : resolved databus value
//   lsb_out, msb_out : multiplier is presenting the result LSB / MSB
//   done             : multiplier finished
module mult_bus_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   opnd_a,
  input  logic [8*N_REQ-1:0]   opnd_b,
  output logic [N_REQ-1:0]     ack,
  output logic [15:0]          result,
  output logic                 err,
  output logic                 busy,
  output logic                 start,
  output logic [7:0]           bus_out,
  output logic                 bus_oe,
  input  logic [7:0]           bus_in,
  input  logic                 lsb_out,
  input  logic                 msb_out,
  input  logic                 done
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSendA = 3'd1;
  localparam logic [2:0] StSendB = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  logic [2:0]       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_grant;
  logic [7:0]       r_opnd_b;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_ack;
  logic [15:0]      r_result;
  logic             r_err;
  logic             r_busy;
  logic             r_start;
  logic [7:0]       r_bus_out;
  logic             r_bus_oe;

  int               w_idx;
  logic [IW-1:0]    w_cand;
  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [7:0]       w_sel_a;
  logic [7:0]       w_sel_b;
  logic [N_REQ-1:0] w_grant_oh;
  logic [IW-1:0]    w_ptr_next;
  logic             w_cnt_last;

  // Round-robin pick: first set request at or after the pointer, wrapping.
  always_comb begin
    w_idx   = 0;
    w_cand  = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_idx  = (int'(r_ptr) + k) % int'(N_REQ);
      w_cand = IW'(w_idx);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
    w_sel_a = opnd_a[{w_pick, 3'b000} +: 8];
    w_sel_b = opnd_b[{w_pick, 3'b000} +: 8];
  end

  always_comb begin
    w_grant_oh          = '0;
    w_grant_oh[r_grant] = 1'b1;
    w_ptr_next          = (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
    w_cnt_last          = (r_cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_opnd_b  <= '0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_bus_out <= '0;
      r_bus_oe  <= 1'b0;
    end else begin
      // ack is a single-cycle pulse unless re-armed below
      r_ack <= '0;
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_grant   <= w_pick;
            r_opnd_b  <= w_sel_b;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_start   <= 1'b1;
            r_bus_oe  <= 1'b1;
            r_bus_out <= w_sel_a;
            r_state   <= StSendA;
          end
        end
        StSendA: begin
          r_start   <= 1'b0;
          r_bus_out <= r_opnd_b;
          r_state   <= StSendB;
        end
        StSendB: begin
          r_bus_oe  <= 1'b0;
          r_bus_out <= '0;
          r_cnt     <= '0;
          r_state   <= StWait;
        end
        StWait: begin
          if (lsb_out) r_result[7:0]  <= bus_in;
          if (msb_out) r_result[15:8] <= bus_in;
          if (done) begin
            r_err   <= 1'b0;
            r_ack   <= w_grant_oh;
            r_state <= StResp;
          end else if (w_cnt_last) begin
            // Abort: a partially captured product is discarded
            r_err    <= 1'b1;
            r_result <= '0;
            r_ack    <= w_grant_oh;
            r_state  <= StResp;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StResp: begin
          r_ptr   <= w_ptr_next;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= StIdle;
        end
        default: begin
          r_busy   <= 1'b0;
          r_start  <= 1'b0;
          r_bus_oe <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign ack     = r_ack;
  assign result  = r_result;
  assign err     = r_err;
  assign busy    = r_busy;
  assign start   = r_start;
  assign bus_out = r_bus_out;
  assign bus_oe  = r_bus_oe;

endmodule

// File: tb/tb_mult_bus_scheduler.sv
module tb_mult_bus_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] opnd_a;
  logic [8*N-1:0] opnd_b;
  logic [N-1:0]   ack;
  logic [15:0]    result;
  logic           err;
  logic           busy;
  logic           start;
  logic [7:0]     bus_out;
  logic           bus_oe;
  logic [7:0]     bus_in;
  logic           lsb_out;
  logic           msb_out;
  logic           done;

  mult_bus_scheduler #(
    .N_REQ   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .opnd_a  (opnd_a),
    .opnd_b  (opnd_b),
    .ack     (ack),
    .result  (result),
    .err     (err),
    .busy    (busy),
    .start   (start),
    .bus_out (bus_out),
    .bus_oe  (bus_oe),
    .bus_in  (bus_in),
    .lsb_out (lsb_out),
    .msb_out (msb_out),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus knobs for the multiplier stub (WAIT-cycle indices, -1 = never)
  int     lat_lsb  = 0;
  int     lat_msb  = 1;
  int     lat_done = 1;
  bit     dup      = 1'b0;
  bit     noise    = 1'b0;
  logic [N-1:0] hold = '0;

  // Behavioural multiplier: learns operands from the bus, replies on a schedule
  initial begin : mult_stub
    int         ph;
    int         w;
    logic [7:0] sa, sb;
    logic [15:0] prod;
    logic       nl, nm, nd;
    logic [7:0] nb;
    ph = 0; w = 0; sa = '0; sb = '0;
    lsb_out = 1'b0; msb_out = 1'b0; done = 1'b0; bus_in = '0;
    forever begin
      @(negedge clk);
      if (rst || (ack != '0)) ph = 0;
      else if (start && bus_oe) begin sa = bus_out; ph = 1; end
      else if (ph == 1 && bus_oe) begin sb = bus_out; ph = 2; w = 0; end
      else if (ph == 2) w++;
      prod = 16'(sa) * 16'(sb);
      nl = 1'b0; nm = 1'b0; nd = 1'b0; nb = '0;
      if (ph == 2) begin
        if (dup && w == 0) begin nl = 1'b1; nb = 8'h5A; end
        if (w == lat_lsb) begin nl = 1'b1; nb = prod[7:0]; end
        if (w == lat_msb) begin nm = 1'b1; nb = prod[15:8]; end
        if (w == lat_done) begin nd = 1'b1; ph = 0; end
      end else if (noise && !rst) begin
        nl = 1'b1; nm = 1'b1; nb = 8'hEE;
      end
      @(posedge clk);
      #1;
      lsb_out = nl; msb_out = nm; done = nd; bus_in = nb;
    end
  end

  // Transaction-level reference model and per-cycle compare
  bit          m_valid = 1'b0;
  bit          m_active = 1'b0;
  int          m_ptr = 0;
  int          m_grant = 0;
  int          m_s = 0;
  int          m_end = 0;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_exp_res;
  logic        m_exp_err;
  logic [15:0] m_hold = '0;

  int          rec_ack[$];
  logic [15:0] rec_res[$];
  logic        rec_err[$];
  int          ack_cyc = 0;
  int          start_cyc = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin : compare
    int         off;
    int         g;
    logic [N-1:0] exp_ack;
    if (m_valid) begin
      off     = cyc - m_s;
      exp_ack = '0;
      if (m_active && cyc == m_end) exp_ack[m_grant] = 1'b1;
      check("start", 32'(start), 32'(m_active && off == 0));
      check("bus_oe", 32'(bus_oe), 32'(m_active && off <= 1));
      check("busy", 32'(busy), 32'(m_active));
      check("ack", 32'(ack), 32'(exp_ack));
      if (m_active && off <= 1) check("bus_out", 32'(bus_out), 32'((off == 0) ? m_a : m_b));
      if (exp_ack != '0) begin
        check("result", 32'(result), 32'(m_exp_res));
        check("err", 32'(err), 32'(m_exp_err));
      end else if (!m_active) begin
        check("result_held", 32'(result), 32'(m_hold));
      end
    end
    if (start === 1'b1) start_cyc = cyc;
    if (ack !== '0 && !$isunknown(ack)) begin
      for (int i = 0; i < N; i++) if (ack[i]) g = i;
      rec_ack.push_back(g);
      rec_res.push_back(result);
      rec_err.push_back(err);
      ack_cyc = cyc;
    end
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_ptr    = 0;
      m_hold   = '0;
    end else if (m_valid) begin
      if (m_active && cyc == m_end) begin
        m_active = 1'b0;
        m_ptr    = (m_grant + 1) % N;
        m_hold   = m_exp_res;
      end else if (!m_active && req != '0) begin
        m_grant   = rr_pick(req, m_ptr);
        m_active  = 1'b1;
        m_s       = cyc + 1;
        m_a       = opnd_a[8*m_grant +: 8];
        m_b       = opnd_b[8*m_grant +: 8];
        m_end     = (lat_done >= 0) ? m_s + 3 + lat_done : m_s + 2 + TO;
        m_exp_err = (lat_done < 0);
        m_exp_res = (lat_done >= 0) ? 16'(m_a) * 16'(m_b) : 16'h0000;
      end
    end
  end

  // One cycle; a requester drops req on the edge that samples its ack
  task automatic tick();
    logic [N-1:0] a;
    @(negedge clk);
    a = ack;
    @(posedge clk);
    #1;
    req = req & ~(a & ~hold);
  endtask

  task automatic run_until_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (req == '0 && !m_active) return;
    end
    errors++;
    $display("FAIL %s: no completion within %0d cycles", name, budget);
  endtask

  task automatic wait_offset(input string name, input int off);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_active && cyc == m_s + off) return;
    end
    errors++;
    $display("FAIL %s: offset %0d never reached", name, off);
  endtask

  task automatic clear_rec();
    rec_ack.delete();
    rec_res.delete();
    rec_err.delete();
  endtask

  task automatic check_acks(input string name, input int n, input int ei[4],
                            input logic [15:0] er[4]);
    check({name, "_count"}, 32'(rec_ack.size()), 32'(n));
    for (int i = 0; i < n && i < rec_ack.size(); i++) begin
      check({name, "_idx"}, 32'(rec_ack[i]), 32'(ei[i]));
      check({name, "_res"}, 32'(rec_res[i]), 32'(er[i]));
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    opnd_a[8*i +: 8] = a;
    opnd_b[8*i +: 8] = b;
  endtask

  task automatic set_lat(input int l, input int m, input int d);
    lat_lsb = l; lat_msb = m; lat_done = d;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_oe"}, 32'(bus_oe), 32'(0));
    check({name, "_busy"}, 32'(busy), 32'(0));
    check({name, "_ack"}, 32'(ack), 32'(0));
    check({name, "_start"}, 32'(start), 32'(0));
    check({name, "_result"}, 32'(result), 32'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    rst = 1'b1; req = '0; opnd_a = '0; opnd_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single request, 0x0F x 0x11
    set_op(0, 8'h0F, 8'h11); set_lat(0, 1, 1); clear_rec();
    req[0] = 1'b1;
    run_until_idle("t1", 100);
    check_acks("t1", 1, '{0, 0, 0, 0}, '{16'h00FF, 0, 0, 0});

    // Minimum latency: everything on the first WAIT edge
    set_op(3, 8'h00, 8'h05); set_lat(0, 0, 0); clear_rec();
    req[3] = 1'b1;
    run_until_idle("t1b", 100);
    check_acks("t1b", 1, '{3, 0, 0, 0}, '{16'h0000, 0, 0, 0});
    check("t1b_latency", 32'(ack_cyc - start_cyc), 32'(3));

    // All four at once, pointer at 0
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'h02);
    set_lat(0, 1, 3); clear_rec();
    req = '1;
    run_until_idle("t2", 300);
    check_acks("t2", 4, '{0, 1, 2, 3}, '{16'd2, 16'd4, 16'd6, 16'd8});

    // req[2] held, req[1] pulsed: 2,1,2 with wrap 3->0->1
    set_op(1, 8'h10, 8'h03); set_op(2, 8'h07, 8'h06); set_lat(1, 2, 2); clear_rec();
    hold = 4'b0100;
    req[2] = 1'b1;
    repeat (3) tick();
    req[1] = 1'b1;
    for (int i = 0; i < 100 && rec_ack.size() < 2; i++) tick();
    hold = '0;
    run_until_idle("t3", 100);
    check_acks("t3", 3, '{2, 1, 2, 0}, '{16'h002A, 16'h0030, 16'h002A, 0});

    // Timeout, then a normal transaction
    set_op(0, 8'h03, 8'h05); set_lat(0, 1, -1); clear_rec();
    req[0] = 1'b1;
    run_until_idle("t4", 100);
    check_acks("t4", 1, '{0, 0, 0, 0}, '{16'h0000, 0, 0, 0});
    if (rec_err.size() > 0) check("t4_err", 32'(rec_err[0]), 32'(1));
    check("t4_latency", 32'(ack_cyc - start_cyc - 2), 32'(TO));
    set_op(1, 8'h07, 8'h09); set_lat(0, 1, 2); clear_rec();
    req[1] = 1'b1;
    run_until_idle("t4b", 100);
    check_acks("t4b", 1, '{1, 0, 0, 0}, '{16'h003F, 0, 0, 0});
    if (rec_err.size() > 0) check("t4b_err", 32'(rec_err[0]), 32'(0));

    // 0xFF x 0xFF, msb with done, stray strobes outside WAIT, repeated lsb
    set_op(2, 8'hFF, 8'hFF); set_lat(1, 2, 2); dup = 1'b1; noise = 1'b1; clear_rec();
    req[2] = 1'b1;
    run_until_idle("t5", 100);
    repeat (2) tick();
    dup = 1'b0; noise = 1'b0;
    check_acks("t5", 1, '{2, 0, 0, 0}, '{16'hFE01, 0, 0, 0});

    // Reset in SEND_B, then in WAIT; pending req[3] granted after each
    set_op(3, 8'h0C, 8'h0D); set_lat(0, 1, 4); clear_rec();
    req[3] = 1'b1;
    wait_offset("t6_sendb", 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t6_rst_sendb");
    wait_offset("t6_wait", 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t6_rst_wait");
    run_until_idle("t6", 100);
    check_acks("t6", 1, '{3, 0, 0, 0}, '{16'h009C, 0, 0, 0});

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
